// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_seq instruction sequencer.
// CTRL_STEP_EN adds the STEP state used for single-step operation.
package ctrl_pkg;

    localparam int unsigned IW   = 16;
    localparam int unsigned REGW = 4;
    localparam int unsigned OPW  = 4;

    localparam logic [OPW-1:0] OP_NOP = 4'h0;
    localparam logic [OPW-1:0] OP_ADD = 4'h1;
    localparam logic [OPW-1:0] OP_SUB = 4'h2;
    localparam logic [OPW-1:0] OP_AND = 4'h3;
    localparam logic [OPW-1:0] OP_OR  = 4'h4;
    localparam logic [OPW-1:0] OP_XOR = 4'h5;
    localparam logic [OPW-1:0] OP_MOV = 4'h6;
    localparam logic [OPW-1:0] OP_LDI = 4'h7;
    localparam logic [OPW-1:0] OP_BRZ = 4'h8;
    localparam logic [OPW-1:0] OP_JMP = 4'h9;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
`ifdef CTRL_STEP_EN
        , ST_STEP
`endif
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] fs;
        logic           imm_sel;
        logic           writes;
        logic           is_branch;
        logic           is_jmp;
        logic           is_hlt;
        logic           illegal;
    } dec_t;

    function automatic logic [OPW-1:0] f_op(input logic [IW-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [REGW-1:0] f_da(input logic [IW-1:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [REGW-1:0] f_aa(input logic [IW-1:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [REGW-1:0] f_ba(input logic [IW-1:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode and register-index legality plus control flags.
// Illegal instructions come out as a NOP with only the illegal flag set.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG = 9
) (
    input  logic [IW-1:0] ir,
    output dec_t          dec
);

    logic uses_a;
    logic uses_b;
    logic bad_op;
    logic reg_bad;

    always_comb begin
        dec     = '0;
        uses_a  = 1'b0;
        uses_b  = 1'b0;
        bad_op  = 1'b0;
        reg_bad = 1'b0;
        case (f_op(ir))
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec.fs     = f_op(ir);
                dec.writes = 1'b1;
                uses_a     = 1'b1;
                uses_b     = 1'b1;
            end
            OP_MOV: begin
                dec.fs     = f_op(ir);
                dec.writes = 1'b1;
                uses_a     = 1'b1;
            end
            OP_LDI: begin
                dec.fs      = f_op(ir);
                dec.writes  = 1'b1;
                dec.imm_sel = 1'b1;
            end
            OP_BRZ:  dec.is_branch = 1'b1;
            OP_JMP:  dec.is_jmp    = 1'b1;
            OP_HLT:  dec.is_hlt    = 1'b1;
            default: bad_op        = 1'b1;
        endcase
        // Only the register fields an opcode actually reads or writes are range-checked
        reg_bad = (dec.writes && (32'(f_da(ir)) >= NREG)) ||
                  (uses_a     && (32'(f_aa(ir)) >= NREG)) ||
                  (uses_b     && (32'(f_ba(ir)) >= NREG));
        if (bad_op || reg_bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multicycle fetch/decode/execute sequencer driving the register file and ALU select.
// CTRL_STEP_EN adds a step input that gates each instruction issue.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned AW   = 8,
    parameter int unsigned NREG = 9
) (
    input  logic            clk,
    input  logic            rstn,
`ifdef CTRL_STEP_EN
    input  logic            step,
`endif
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_ack,
    input  logic [IW-1:0]   mem_rdata,
    input  logic            z_flag,
    output logic [REGW-1:0] DA,
    output logic [REGW-1:0] AA,
    output logic [REGW-1:0] BA,
    output logic            RW,
    output logic [OPW-1:0]  fs,
    output logic            imm_sel,
    output logic            halted,
    output logic            illegal
);

`ifdef CTRL_STEP_EN
    localparam state_t ST_DONE = ST_STEP;
`else
    localparam state_t ST_DONE = ST_FETCH;
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q, ir_d;
    dec_t          dec_q, dec_d, dec_c;
    logic          mem_req_d, rw_d, halted_d, illegal_d;

    // Decode the word as it arrives so the control flags are registered alongside IR
    ctrl_decode #(.NREG(NREG)) u_decode (
        .ir  (mem_rdata),
        .dec (dec_c)
    );

    assign mem_addr = pc_q;
    assign DA       = f_da(ir_q);
    assign AA       = f_aa(ir_q);
    assign BA       = f_ba(ir_q);
    assign fs       = dec_q.fs;
    assign imm_sel  = dec_q.imm_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            dec_q   <= '0;
            mem_req <= 1'b0;
            RW      <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dec_q   <= dec_d;
            mem_req <= mem_req_d;
            RW      <= rw_d;
            halted  <= halted_d;
            illegal <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dec_d   = dec_q;
        case (state_q)
            ST_FETCH: begin
                // The first cycle after reset has mem_req low, so no ack is taken there
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    dec_d   = dec_c;
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec_q.is_branch && z_flag) pc_d = pc_q + AW'($signed(ir_q[7:0]));
                if (dec_q.is_jmp)              pc_d = ir_q[AW-1:0];
                if (dec_q.is_hlt)              state_d = ST_HALT;
                else if (dec_q.writes)         state_d = ST_WB;
                else                           state_d = ST_DONE;
            end
            ST_WB:   state_d = ST_DONE;
            ST_HALT: state_d = ST_HALT;
`ifdef CTRL_STEP_EN
            ST_STEP: if (step) state_d = ST_FETCH;
`endif
            default: state_d = ST_FETCH;
        endcase
        mem_req_d = (state_d == ST_FETCH);
        rw_d      = (state_d == ST_WB);
        halted_d  = (state_d == ST_HALT);
        illegal_d = (state_d == ST_EXEC) && dec_d.illegal;
    end

endmodule
